// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the instruction-fetch front end.
//
//   DEFAULT_XLEN  : default datapath / address width
//   NOP_INSTR     : canonical RISC-V NOP (addi x0, x0, 0) used for bubbles
//   fetch_state_t : fetch FSM encoding
//       REQ   - request slot open, imem_req may be raised
//       WAIT  - request accepted, waiting for its response
//       DRAIN - a redirect flushed the fetch; the stale response is still
//               owed by memory and must be swallowed when it arrives
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int          DEFAULT_XLEN = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage : riscv_pkg

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage sitting directly in front of the IF/ID pipeline
//   registers. Owns the program counter, issues one instruction-memory read
//   at a time, and presents {if_pc, if_instr, if_valid} downstream. While a
//   fetch is in flight the output slot carries a NOP bubble.
//
// Handshakes:
//   imem_req/imem_ready : a request transfers on a rising edge where both are
//                         high; imem_addr must be stable while imem_req is
//                         high. Only one request is ever outstanding.
//   imem_rvalid         : one response per accepted request, never earlier
//                         than the cycle after acceptance; it is only looked
//                         at in WAIT or DRAIN.
//   if_valid/stall      : the presented instruction is consumed on every
//                         edge with if_valid=1 and stall=0; with stall=1 it
//                         is held unchanged.
//
// Ports:
//   clk          in   1     rising-edge clock
//   rst          in   1     asynchronous, active-low reset
//   stall        in   1     downstream hold
//   redirect     in   1     branch/jump taken, flush and refetch
//   redirect_pc  in   XLEN  redirect target (bits [1:0] forced to 0)
//   imem_req     out  1     fetch request valid
//   imem_addr    out  XLEN  fetch address (word aligned)
//   imem_ready   in   1     memory accepts the request this cycle
//   imem_rvalid  in   1     read data valid
//   imem_rdata   in   32    instruction word
//   if_pc        out  XLEN  PC of the presented instruction
//   if_instr     out  32    presented instruction (NOP when if_valid=0)
//   if_valid     out  1     presented instruction is real
//   dbg_state    out  2     current fetch FSM state
// ---------------------------------------------------------------------------
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic                 imem_req,
    output logic [XLEN-1:0]      imem_addr,
    input  logic                 imem_ready,
    input  logic                 imem_rvalid,
    input  logic [31:0]          imem_rdata,
    output logic [XLEN-1:0]      if_pc,
    output logic [31:0]          if_instr,
    output logic                 if_valid,
    output fetch_state_t         dbg_state
);

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    fetch_state_t      r_state;
    logic [XLEN-1:0]   r_pc;        // next address to fetch
    logic [XLEN-1:0]   r_req_pc;    // address of the request in flight
    logic [XLEN-1:0]   r_if_pc;
    logic [31:0]       r_if_instr;
    logic              r_if_valid;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic              w_imem_req;
    logic              w_accept;
    logic              w_consume;
    logic [XLEN-1:0]   w_redirect_pc;
    logic [XLEN-1:0]   w_next_pc;

    // A request is only raised when the output slot is empty or is being
    // consumed on this edge, so by the time the response lands in WAIT the
    // slot is guaranteed free. Redirect suppresses the request so nothing can
    // be accepted on the flush edge. The rst term keeps imem_req low for the
    // whole time reset is asserted.
    always_comb begin
        w_imem_req = 1'b0;
        if (rst && (r_state == REQ)) begin
            w_imem_req = (!r_if_valid || !stall) && !redirect;
        end
    end

    assign w_accept      = w_imem_req && imem_ready;
    assign w_consume     = r_if_valid && !stall;
    assign w_redirect_pc = redirect_pc & ALIGN_MASK;
    // Plain modular add: 0xFFFF_FFFC + 4 wraps to 0.
    assign w_next_pc     = r_req_pc + PC_STEP;

    // -----------------------------------------------------------------------
    // FSM, PC and output slot
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= REQ;
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_if_pc    <= '0;
            r_if_instr <= NOP_INSTR;
            r_if_valid <= 1'b0;
        end else begin
            // Consumption empties the slot; a word loading on the same edge
            // (WAIT branch below) overrides this.
            if (w_consume) begin
                r_if_valid <= 1'b0;
                r_if_instr <= NOP_INSTR;
            end

            if (redirect) begin
                // Flush wins over stall and over any response on this edge.
                r_pc       <= w_redirect_pc;
                r_if_valid <= 1'b0;
                r_if_instr <= NOP_INSTR;
                unique case (r_state)
                    // A response still owed by memory must be swallowed.
                    WAIT:    r_state <= imem_rvalid ? REQ : DRAIN;
                    DRAIN:   r_state <= imem_rvalid ? REQ : DRAIN;
                    default: r_state <= REQ;
                endcase
            end else begin
                unique case (r_state)
                    REQ: begin
                        if (w_accept) begin
                            r_req_pc <= r_pc;
                            r_state  <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_rvalid) begin
                            r_if_pc    <= r_req_pc;
                            r_if_instr <= imem_rdata;
                            r_if_valid <= 1'b1;
                            r_pc       <= w_next_pc;
                            r_state    <= REQ;
                        end
                    end
                    DRAIN: begin
                        // Stale data is dropped; r_pc already holds the target.
                        if (imem_rvalid) begin
                            r_state <= REQ;
                        end
                    end
                    default: r_state <= REQ;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign imem_req  = w_imem_req;
    assign imem_addr = r_pc;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign if_valid  = r_if_valid;
    assign dbg_state = r_state;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Inputs change 1 time unit after a rising
// edge; outputs are checked after they settle, well away from the edge. A
// small memory model answers accepted requests with 0xA000_0000 + addr after
// a programmable latency.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         stall;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ready;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic [31:0]  if_pc;
    logic [31:0]  if_instr;
    logic         if_valid;
    fetch_state_t dbg_state;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_valid    (if_valid),
        .dbg_state   (dbg_state)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] instr);
        check({tag, "_valid"}, 32'(if_valid), 32'(v));
        check({tag, "_pc"}, if_pc, pc);
        check({tag, "_instr"}, if_instr, instr);
    endtask

    // memory model
    logic        auto_mem;
    int          mem_lat;
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;

    task automatic tick();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = auto_mem && imem_req && imem_ready;
        a   = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            pend_cnt  = mem_lat;
            pend_addr = a;
        end
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hA000_0000 + pend_addr;
                pend        = 1'b0;
            end
        end
    endtask

    // scoreboard: instructions actually consumed downstream, in order
    logic [31:0] exp_q[$];
    int unsigned sb_seen = 0;

    always @(negedge clk) begin
        if (if_valid && !stall && !redirect) begin
            logic [31:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : NOP;
            sb_seen++;
            check("sb_instr", if_instr, e);
        end
    end

    initial begin
        exp_q = {32'hA000_0000, 32'hA000_0004, 32'hA000_0008, 32'hA000_0100,
                 32'hA000_0200, 32'hA000_0204, 32'h9FFF_FFFC, 32'hA000_0000};
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        auto_mem = 1'b1; mem_lat = 1; pend = 1'b0; pend_cnt = 0; pend_addr = '0;
        tick(); tick();

        // reset state
        check_out("rst", 1'b0, 32'h0, NOP);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(REQ));
        rst = 1'b1; #1;

        // streaming fetch, 1-cycle latency
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        tick();
        check("c1_state", 32'(dbg_state), 32'(WAIT));
        check("c1_req", 32'(imem_req), 32'd0);
        check("c1_valid", 32'(if_valid), 32'd0);
        tick();
        check_out("c2", 1'b1, 32'h0, 32'hA000_0000);
        check("c2_addr", imem_addr, 32'h4);
        check("c2_req", 32'(imem_req), 32'd1);
        tick();
        check("c3_valid", 32'(if_valid), 32'd0);
        tick();
        check_out("c4", 1'b1, 32'h4, 32'hA000_0004);

        // stall holds output and blocks requests
        stall = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            check("stall_req", 32'(imem_req), 32'd0);
            check_out("stall", 1'b1, 32'h4, 32'hA000_0004);
            tick();
        end
        stall = 1'b0; #1;
        check("unstall_req", 32'(imem_req), 32'd1);
        check("unstall_addr", imem_addr, 32'h8);
        tick(); tick();
        check_out("c11", 1'b1, 32'h8, 32'hA000_0008);

        // redirect in WAIT, stale response arrives two cycles later
        mem_lat = 3;
        check("c11_addr", imem_addr, 32'hC);
        tick();
        check("c12_state", 32'(dbg_state), 32'(WAIT));
        redirect = 1'b1; redirect_pc = 32'h100; #1;
        check("redir_req", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0; #1;
        check("drain_state", 32'(dbg_state), 32'(DRAIN));
        check("drain_valid", 32'(if_valid), 32'd0);
        tick();
        check("drain2_state", 32'(dbg_state), 32'(DRAIN));
        check("drain2_req", 32'(imem_req), 32'd0);
        tick();
        check("post_drain_state", 32'(dbg_state), 32'(REQ));
        check("post_drain_valid", 32'(if_valid), 32'd0);
        check("post_drain_req", 32'(imem_req), 32'd1);
        check("post_drain_addr", imem_addr, 32'h100);
        mem_lat = 1;
        tick(); tick();
        check_out("c17", 1'b1, 32'h100, 32'hA000_0100);
        check("c17_addr", imem_addr, 32'h104);
        tick();

        // redirect coincident with rvalid, misaligned target
        check("c18_state", 32'(dbg_state), 32'(WAIT));
        redirect = 1'b1; redirect_pc = 32'h203; #1;
        tick();
        redirect = 1'b0; #1;
        check_out("c19", 1'b0, 32'h100, NOP);
        check("c19_state", 32'(dbg_state), 32'(REQ));
        check("c19_addr", imem_addr, 32'h200);
        check("c19_req", 32'(imem_req), 32'd1);
        tick(); tick();
        check_out("c21", 1'b1, 32'h200, 32'hA000_0200);

        // memory not ready: request held with stable address
        imem_ready = 1'b0; #1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("nrdy_req", 32'(imem_req), 32'd1);
            check("nrdy_addr", imem_addr, 32'h204);
            check("nrdy_state", 32'(dbg_state), 32'(REQ));
            check("nrdy_instr", if_instr, NOP);
            tick();
        end
        imem_ready = 1'b1; #1;
        tick(); tick();
        check_out("c27", 1'b1, 32'h204, 32'hA000_0204);

        // async reset during WAIT, stray response afterwards
        auto_mem = 1'b0; #1;
        tick();
        check("c28_state", 32'(dbg_state), 32'(WAIT));
        rst = 1'b0; #1;
        check_out("arst", 1'b0, 32'h0, NOP);
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_state", 32'(dbg_state), 32'(REQ));
        tick();
        rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; imem_ready = 1'b0; #1;
        check("rel_req", 32'(imem_req), 32'd1);
        check("rel_addr", imem_addr, 32'h0);
        tick();
        check_out("stray", 1'b0, 32'h0, NOP);
        check("stray_state", 32'(dbg_state), 32'(REQ));
        imem_ready = 1'b1; auto_mem = 1'b1; #1;
        tick(); tick();
        check_out("c32", 1'b1, 32'h0, 32'hA000_0000);

        // PC wrap at top of address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        check("wrap_redir_req", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0; #1;
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        check("wrap_req", 32'(imem_req), 32'd1);
        tick(); tick();
        check_out("wrap_top", 1'b1, 32'hFFFF_FFFC, 32'h9FFF_FFFC);
        check("wrap_addr_zero", imem_addr, 32'h0);
        tick(); tick();
        check_out("wrap_zero", 1'b1, 32'h0, 32'hA000_0000);
        tick();

        check("sb_seen", sb_seen, 32'd8);
        check("sb_left", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline registers.
- Owns the program counter and issues one-at-a-time requests to instruction memory over a req/ready + rvalid handshake.
- Presents {if_pc, if_instr} to the pipeline registers, inserting NOP bubbles while a fetch is outstanding.
- Honours the downstream stall and branch/jump redirects.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  downstream hold; pipeline registers keep their value while high.
- redirect  in  1  branch/jump taken; flush and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored, treated as 0.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address (word aligned).
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; earliest the cycle after acceptance.
- imem_rdata  in  32  instruction word.
- if_pc  out  XLEN  PC of the presented instruction.
- if_instr  out  32  presented instruction; NOP (32'h0000_0013) when if_valid=0.
- if_valid  out  1  presented instruction is real (not a bubble).

Behaviour:
- Reset (async, rst=0): state=REQ, pc=RESET_PC, if_valid=0, if_pc=0, if_instr=NOP, imem_req=0 while rst low. Reset mid-transaction discards any outstanding response; rvalid is sampled only in WAIT/DRAIN.
- FSM states REQ, WAIT, DRAIN.
- REQ:
  - imem_req = (!if_valid || !stall) && !redirect; imem_addr = pc.
  - On req&&ready: latch req_pc=pc, go to WAIT.
- WAIT:
  - imem_req=0.
  - On rvalid: if_pc<=req_pc, if_instr<=rdata, if_valid<=1, pc<=req_pc+4 (mod 2^XLEN, wraps), go to REQ.
- DRAIN:
  - Entered when a redirect hits while a response is outstanding.
  - On rvalid the data is dropped, then go to REQ.
- Consumption: each edge with if_valid=1 and stall=0 consumes the output. if_valid<=0 and if_instr<=NOP unless a new word loads on that same edge.
- Stall: with if_valid=1 and stall=1, the output holds and no new request is issued. A request is only issued when the output slot is empty or being consumed, so WAIT always sees an empty slot.
- Redirect (highest priority, ignores stall):
  - At the edge: pc<=redirect_pc&~3, if_valid<=0, if_instr<=NOP.
  - State from WAIT without rvalid -> DRAIN. From WAIT with rvalid on the same edge -> REQ (response dropped). From REQ or DRAIN -> REQ (DRAIN stays DRAIN if its response is still pending).
  - A request accepted on the redirect edge cannot occur (imem_req gated by redirect).
- Throughput: 1 instruction per 2 cycles with 1-cycle memory latency. Each extra latency cycle adds one bubble.
- pc+4 wraps from 32'hFFFF_FFFC to 0 without error.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR constant (32'h0000_0013).
  - fetch_state_t enum {REQ, WAIT, DRAIN}.
  - XLEN default.
- No sub-module needed. PC and output registers are inline; the existing pipeline register downstream is instantiated by the parent, not here.

Test Plan:
- Reset release, memory ready=1 with 1-cycle latency returning 0xA0000000+addr: imem_addr sequence 0x0, 0x4, 0x8. if_valid pulses every 2nd cycle with if_pc 0x0/0x4/0x8 and if_instr 0xA0000000/04/08.
- Stall=1 for 5 cycles while if_valid=1 at pc 0x4: if_pc/if_instr hold, imem_req=0 throughout. After release, next request addr=0x8.
- Redirect to 0x100 in WAIT with response arriving 2 cycles later: the late response is dropped, if_valid stays 0, next imem_addr=0x100, if_pc=0x100.
- Redirect to 0x203 coincident with rvalid: rdata discarded, next imem_addr=0x200.
- imem_ready low for 3 cycles in REQ: imem_req stays 1 with a stable address, the FSM stays in REQ, and if_instr=NOP.
- rst pulsed low during WAIT: outputs reset immediately. After release, the stray rvalid is ignored and fetch restarts at RESET_PC. Also run pc=0xFFFF_FFFC: next address is 0x0.
